// File: rtl/ins_mem_prog.sv
// Loadable instruction memory for the MIPS IF stage: LOAD state accepts program words,
// RUN state serves registered 1-cycle fetches with stall/flush control and bad-address faults.
module ins_mem_prog #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              prog_start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fault,
  output logic              loading,
  output logic [ADDR_W:0]   prog_count
);

  localparam logic [0:0]    ST_LOAD   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_idx;
  logic              bad;

  // Control semantics: every input is sampled at the rising edge; there is no back-pressure.
  // prog_start/prog_done are single-cycle pulses, prog_we is a write strobe honoured only in
  // LOAD, and the instruction/instr_valid/fault triple appears one edge after its request.
  assign rd_idx  = fetch_addr[ADDR_W+1:2];
  assign bad     = (fetch_addr[1:0] != 2'b00) | ((fetch_addr >> 2) >= 32'(DEPTH));
  assign loading = (state == ST_LOAD);

  // The array has no reset so loaded programs survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      prog_count <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (prog_start) begin
            prog_count <= '0;
          end else begin
            if (prog_we && prog_count != COUNT_MAX) prog_count <= prog_count + 1'b1;
            if (prog_done) state <= ST_RUN;
          end
        end
        default: begin
          if (prog_start) begin
            state      <= ST_LOAD;
            prog_count <= '0;
          end
        end
      endcase
    end
  end

  // Fetch path priority in RUN: flush, then stall (hold), then fetch, then idle bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (state == ST_LOAD || prog_start || flush) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (stall) begin
      instruction <= instruction;
      instr_valid <= instr_valid;
      fault       <= fault;
    end else if (fetch_en) begin
      instruction <= bad ? NOP_WORD : mem[rd_idx];
      instr_valid <= 1'b1;
      fault       <= bad;
    end else begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ins_mem_prog.sv
// Directed bench for ins_mem_prog: expected {loading,valid,fault,instruction} tuples are
// queued as each cycle's stimulus is driven and checked one edge later.
module tb_ins_mem_prog;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       fetch_addr;
  logic              fetch_en, stall, flush, prog_start, prog_we, prog_done;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid, fault, loading;
  logic [ADDR_W:0]   prog_count;

  int total = 0;
  int bad   = 0;
  logic [DATA_W+2:0] exp_q[$];
  logic [31:0] prog_words [4];
  logic [31:0] model [DEPTH];

  ins_mem_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr), .fetch_en(fetch_en),
    .stall(stall), .flush(flush), .prog_start(prog_start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_done(prog_done),
    .instruction(instruction), .instr_valid(instr_valid), .fault(fault),
    .loading(loading), .prog_count(prog_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs for the current stimulus, then check them after the edge.
  task automatic tick(input string tag, input logic e_load, input logic e_valid,
                      input logic e_fault, input logic [DATA_W-1:0] e_instr);
    logic [DATA_W+2:0] e;
    exp_q.push_back({e_load, e_valid, e_fault, e_instr});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_q"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'({loading, instr_valid, fault, instruction}), 64'(e));
    end
  endtask

  initial begin
    prog_words[0] = 32'h2008_0005;
    prog_words[1] = 32'h2009_0003;
    prog_words[2] = 32'h0109_5020;
    prog_words[3] = 32'hAC0A_0000;
    rst_n = 1'b0; fetch_addr = '0; fetch_en = 0; stall = 0; flush = 0;
    prog_start = 0; prog_we = 0; prog_done = 0; prog_addr = '0; prog_data = '0;

    // Reset values
    #2;
    chk("rst_outputs", 64'({loading, instr_valid, fault, instruction}), 64'({1'b1, 1'b0, 1'b0, NOP}));
    chk("rst_count", 64'(prog_count), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // T1: load four words, fetch them back
    prog_start = 1;
    tick("t1_start", 1, 0, 0, NOP);
    prog_start = 0; fetch_en = 1;
    for (int i = 0; i < 4; i++) begin
      prog_we = 1; prog_addr = ADDR_W'(i); prog_data = prog_words[i];
      tick("t1_load_nofetch", 1, 0, 0, NOP);
    end
    prog_we = 0; fetch_en = 0; prog_done = 1;
    tick("t1_done", 0, 0, 0, NOP);
    chk("t1_count", 64'(prog_count), 64'd4);
    prog_done = 0; fetch_en = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 32'(i * 4);
      tick("t1_fetch", 0, 1, 0, prog_words[i]);
    end

    // T2: stall holds the previous word
    fetch_addr = 32'h4;
    tick("t2_fetch4", 0, 1, 0, prog_words[1]);
    stall = 1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) tick("t2_stall_hold", 0, 1, 0, prog_words[1]);
    stall = 0;
    tick("t2_release", 0, 1, 0, prog_words[2]);

    // T3: flush beats stall
    stall = 1; flush = 1;
    tick("t3_flush_over_stall", 0, 0, 0, NOP);
    stall = 0; flush = 0;

    // T4: misaligned and out-of-range fetches fault without aliasing
    fetch_addr = 32'h6;
    tick("t4_misaligned", 0, 1, 1, NOP);
    fetch_addr = 32'(DEPTH * 4);
    tick("t4_out_of_range", 0, 1, 1, NOP);
    fetch_addr = 32'hFFFF_FFFC;
    tick("t4_top_addr", 0, 1, 1, NOP);
    fetch_en = 0;
    tick("t4_idle", 0, 0, 0, NOP);

    // T5: writes ignored in RUN; start beats done
    fetch_en = 1; fetch_addr = 32'h0; prog_we = 1; prog_addr = '0; prog_data = 32'hFFFF_FFFF;
    tick("t5_we_in_run", 0, 1, 0, prog_words[0]);
    prog_we = 0;
    tick("t5_word0_kept", 0, 1, 0, prog_words[0]);
    prog_start = 1; prog_done = 1;
    tick("t5_start_from_run", 1, 0, 0, NOP);
    tick("t5_start_beats_done", 1, 0, 0, NOP);
    prog_start = 0; prog_done = 0;
    tick("t5_load_fetch_invalid", 1, 0, 0, NOP);
    chk("t5_count_cleared", 64'(prog_count), 64'd0);
    prog_done = 1;
    tick("t5_back_to_run", 0, 0, 0, NOP);
    prog_done = 0;

    // T6: asynchronous reset mid-fetch, memory contents persist
    fetch_addr = 32'h8;
    tick("t6_pre_reset", 0, 1, 0, prog_words[2]);
    fetch_addr = 32'hC;
    #2; rst_n = 1'b0; #1;
    chk("t6_async_reset", 64'({loading, instr_valid, fault, instruction}), 64'({1'b1, 1'b0, 1'b0, NOP}));
    @(posedge clk); #1; rst_n = 1'b1;
    fetch_en = 0; prog_done = 1;
    tick("t6_done_noload", 0, 0, 0, NOP);
    prog_done = 0; fetch_en = 1; fetch_addr = 32'h8;
    tick("t6_kept_word2", 0, 1, 0, prog_words[2]);
    fetch_addr = 32'h0;
    tick("t6_kept_word0", 0, 1, 0, prog_words[0]);

    // Saturating prog_count over a full reload, then spot-check random words
    prog_start = 1; fetch_en = 0;
    tick("sat_start", 1, 0, 0, NOP);
    prog_start = 0; prog_we = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      prog_addr = ADDR_W'(i);
      prog_data = $urandom;
      model[i % DEPTH] = prog_data;
      tick("sat_load", 1, 0, 0, NOP);
      if (i == DEPTH - 2) chk("sat_count_depth_m1", 64'(prog_count), 64'(DEPTH - 1));
    end
    chk("sat_count_max", 64'(prog_count), 64'(DEPTH));
    prog_we = 0; prog_done = 1;
    tick("sat_done", 0, 0, 0, NOP);
    prog_done = 0; fetch_en = 1;
    for (int i = 0; i < 6; i++) begin
      int idx;
      idx = $urandom_range(DEPTH - 1, 0);
      fetch_addr = 32'(idx * 4);
      tick("sat_rand_fetch", 0, 1, 0, model[idx]);
    end
    fetch_addr = 32'(DEPTH - 1) * 4;
    tick("sat_last_word", 0, 1, 0, model[DEPTH-1]);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
